// File: rtl/bram_tile_loader.sv
// bram_tile_loader: copies a rectangular tile of 8-bit operands (one per 32-bit BRAM word, low
// byte) from a PS-shared BRAM into the per-lane A or W RAM write ports of the systolic system.
// The engine is start/busy/done. It reads one (line, lane) element per cycle, and each write
// follows its read by exactly one cycle.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, sel            load request (IDLE only); target buffer 0=A, 1=W
//   src_base              BRAM byte address of element (0,0)
//   dst_line_base         first destination line in the lane RAMs
//   num_lines, num_lanes  tile shape; num_lanes of 0 or > LANES means LANES
//   busy, done            engine status; done is a one-cycle pulse
//   bram_addr/en/rdata    BRAM read port with a fixed read latency of 1
//   a_w_*, w_w_*          byte address / one-hot lane enable / data write ports
//
// Build option: define ZERO_PAD_EN to write zeros into lanes at or beyond num_lanes. Those
// lanes still issue no BRAM read. Without the macro they are skipped entirely.
module bram_tile_loader #(
  parameter int unsigned ARRAY_N     = 8,
  parameter int unsigned ARRAY_M     = 8,
  parameter int unsigned RAM_SIZE    = 256,
  parameter int unsigned ADDR_WIDTH  = $clog2(RAM_SIZE),
  parameter int unsigned BRAM_RD_LAT = 1,
  localparam int unsigned MAX_LANES  = (ARRAY_N > ARRAY_M) ? ARRAY_N : ARRAY_M,
  localparam int unsigned LANE_W     = $clog2(MAX_LANES) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sel,
  input  logic [31:0]           src_base,
  input  logic [ADDR_WIDTH-1:0] dst_line_base,
  input  logic [ADDR_WIDTH:0]   num_lines,
  input  logic [LANE_W-1:0]     num_lanes,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           bram_addr,
  output logic                  bram_en,
  input  logic [31:0]           bram_rdata,
  output logic [31:0]           a_w_addr,
  output logic [31:0]           a_w_data,
  output logic [ARRAY_N-1:0]    a_w_en,
  output logic [31:0]           w_w_addr,
  output logic [31:0]           w_w_data,
  output logic [ARRAY_M-1:0]    w_w_en
);

  localparam int unsigned LINE_W = ADDR_WIDTH + 1;

  // The write stage assumes data arrives exactly one cycle after the read.
  if (BRAM_RD_LAT != 1) begin : g_lat_check
    $error("bram_tile_loader supports BRAM_RD_LAT == 1 only");
  end

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                  state_q;
  logic                    sel_q;
  logic [31:0]             src_base_q;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [LINE_W-1:0]       num_lines_q;
  logic [LANE_W-1:0]       lanes_q;     // LANES of the selected buffer
  logic [LANE_W-1:0]       eff_q;       // clamped num_lanes
  logic [LANE_W-1:0]       lane_q;
  logic [LINE_W-1:0]       line_q;

  // Write pipeline: position of the read issued in the previous cycle.
  logic                    wr_valid_q;
  logic [LANE_W-1:0]       wr_lane_q;
  logic [LINE_W-1:0]       wr_line_q;
`ifdef ZERO_PAD_EN
  logic                    wr_pad_q;
`endif

  logic [LANE_W-1:0]       lanes_in, eff_in, lane_nxt;
  logic [LINE_W-1:0]       line_nxt;
  logic                    last_pos, last_lane, rd_hit;
  logic [31:0]             rd_addr_nxt, wr_addr, wr_data;
  logic [MAX_LANES-1:0]    lane_onehot;

  always_comb begin
    lanes_in    = sel ? LANE_W'(ARRAY_M) : LANE_W'(ARRAY_N);
    eff_in      = (num_lanes == '0 || num_lanes > lanes_in) ? lanes_in : num_lanes;
    last_lane   = (lane_q == lanes_q - LANE_W'(1));
    last_pos    = last_lane && (line_q == num_lines_q - LINE_W'(1));
    lane_nxt    = last_lane ? '0 : lane_q + LANE_W'(1);
    line_nxt    = last_lane ? line_q + LINE_W'(1) : line_q;
    rd_hit      = (lane_q < eff_q);
    // Source stride is always LANES words per line, whatever num_lanes is.
    rd_addr_nxt = src_base_q + ((32'(line_nxt) * 32'(lanes_q) + 32'(lane_nxt)) << 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      sel_q       <= 1'b0;
      src_base_q  <= '0;
      dst_q       <= '0;
      num_lines_q <= '0;
      lanes_q     <= '0;
      eff_q       <= '0;
      lane_q      <= '0;
      line_q      <= '0;
      wr_valid_q  <= 1'b0;
      wr_lane_q   <= '0;
      wr_line_q   <= '0;
`ifdef ZERO_PAD_EN
      wr_pad_q    <= 1'b0;
`endif
    end else begin
      wr_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel_q       <= sel;
            src_base_q  <= src_base;
            dst_q       <= dst_line_base;
            num_lines_q <= num_lines;
            lanes_q     <= lanes_in;
            eff_q       <= eff_in;
            lane_q      <= '0;
            line_q      <= '0;
            busy        <= 1'b1;
            if (num_lines == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              // Lane 0 is always valid because eff_in >= 1.
              state_q   <= StRead;
              bram_en   <= 1'b1;
              bram_addr <= src_base;
            end
          end
        end
        StRead: begin
          wr_lane_q <= lane_q;
          wr_line_q <= line_q;
`ifdef ZERO_PAD_EN
          wr_valid_q <= 1'b1;
          wr_pad_q   <= !rd_hit;
`else
          wr_valid_q <= rd_hit;
`endif
          if (last_pos) begin
            state_q   <= StDrain;
            bram_en   <= 1'b0;
            bram_addr <= '0;
          end else begin
            lane_q    <= lane_nxt;
            line_q    <= line_nxt;
            bram_en   <= (lane_nxt < eff_q);
            bram_addr <= (lane_nxt < eff_q) ? rd_addr_nxt : '0;
          end
        end
        StDrain: begin
          state_q <= StDone;
          done    <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write port: byte address lets the downstream divide by LANES*4 to recover the line.
  always_comb begin
    wr_addr     = ((32'(dst_q) + 32'(wr_line_q)) * 32'(lanes_q) + 32'(wr_lane_q)) << 2;
    lane_onehot = MAX_LANES'(1) << wr_lane_q;
`ifdef ZERO_PAD_EN
    wr_data     = wr_pad_q ? '0 : bram_rdata;
`else
    wr_data     = bram_rdata;
`endif
    a_w_en      = '0;
    a_w_addr    = '0;
    a_w_data    = '0;
    w_w_en      = '0;
    w_w_addr    = '0;
    w_w_data    = '0;
    if (wr_valid_q) begin
      if (sel_q) begin
        w_w_en   = lane_onehot[ARRAY_M-1:0];
        w_w_addr = wr_addr;
        w_w_data = wr_data;
      end else begin
        a_w_en   = lane_onehot[ARRAY_N-1:0];
        a_w_addr = wr_addr;
        a_w_data = wr_data;
      end
    end
  end

endmodule
